// File: rtl/spi_arbiter.sv
// Round-robin arbiter that lets two requesters share one SPI byte master.
// It owns the grant, counts bytes in each direction and pulses per-requester handshakes.
module spi_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] len0,
    input  logic [3:0] len1,
    input  logic [7:0] tx_data0,
    input  logic [7:0] tx_data1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       tx_next0,
    output logic       tx_next1,
    output logic [7:0] rx_data,
    output logic       rx_valid0,
    output logic       rx_valid1,
    output logic       done0,
    output logic       done1,
    output logic       m_en,
    output logic [7:0] m_tx_byte,
    input  logic       m_tx_ready,
    input  logic       m_rx_ready,
    input  logic [7:0] m_rx_byte
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, GAP} state_t;

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic [3:0] len_q, len_d;
    logic [3:0] sent_cnt_q, sent_cnt_d;
    logic [3:0] rx_cnt_q, rx_cnt_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [1:0] tx_next_q, tx_next_d;
    logic [1:0] rx_valid_q, rx_valid_d;
    logic [1:0] done_q, done_d;

    logic       active;
    logic       any_req;
    logic       win1;
    logic       tx_last;
    logic       rx_last;
    logic [3:0] win_len;

    assign active  = (state_q == RUN) || (state_q == DRAIN);
    assign any_req = req0 || req1;
    // On a tie the requester that was not granted last wins.
    assign win1    = req1 && (!req0 || !last_q);
    assign win_len = win1 ? len1 : len0;
    assign tx_last = (sent_cnt_q + 4'd1) == len_q;
    assign rx_last = (rx_cnt_q + 4'd1) == len_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            len_q      <= 4'd0;
            sent_cnt_q <= 4'd0;
            rx_cnt_q   <= 4'd0;
            rx_data_q  <= 8'h00;
            tx_next_q  <= 2'b00;
            rx_valid_q <= 2'b00;
            done_q     <= 2'b00;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            len_q      <= len_d;
            sent_cnt_q <= sent_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_data_q  <= rx_data_d;
            tx_next_q  <= tx_next_d;
            rx_valid_q <= rx_valid_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = RUN;
            RUN:     if (m_tx_ready && tx_last) state_d = DRAIN;
            DRAIN:   if (m_rx_ready && rx_last) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d    = owner_q;
        last_d     = last_q;
        len_d      = len_q;
        sent_cnt_d = sent_cnt_q;
        rx_cnt_d   = rx_cnt_q;
        rx_data_d  = rx_data_q;
        tx_next_d  = 2'b00;
        rx_valid_d = 2'b00;
        done_d     = 2'b00;

        // A zero length is served as a single byte.
        if (state_q == IDLE && any_req) begin
            owner_d    = win1;
            last_d     = win1;
            len_d      = (win_len == 4'd0) ? 4'd1 : win_len;
            sent_cnt_d = 4'd0;
            rx_cnt_d   = 4'd0;
        end

        if (state_q == RUN && m_tx_ready) begin
            sent_cnt_d = sent_cnt_q + 4'd1;
            if (!tx_last) tx_next_d[owner_q] = 1'b1;
        end

        if (active && m_rx_ready) begin
            rx_data_d           = m_rx_byte;
            rx_cnt_d            = rx_cnt_q + 4'd1;
            rx_valid_d[owner_q] = 1'b1;
            if (state_q == DRAIN && rx_last) done_d[owner_q] = 1'b1;
        end
    end

    assign gnt0      = active && !owner_q;
    assign gnt1      = active && owner_q;
    assign m_en      = (state_q == RUN);
    assign m_tx_byte = gnt0 ? tx_data0 : (gnt1 ? tx_data1 : 8'h00);
    assign tx_next0  = tx_next_q[0];
    assign tx_next1  = tx_next_q[1];
    assign rx_valid0 = rx_valid_q[0];
    assign rx_valid1 = rx_valid_q[1];
    assign done0     = done_q[0];
    assign done1     = done_q[1];
    assign rx_data   = rx_data_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: the bench plays both requesters and a loopback SPI master.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_spi_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [3:0] len0, len1;
    logic [7:0] tx_data0, tx_data1;
    logic       gnt0, gnt1, tx_next0, tx_next1;
    logic [7:0] rx_data;
    logic       rx_valid0, rx_valid1, done0, done1, m_en;
    logic [7:0] m_tx_byte;
    logic       m_tx_ready, m_rx_ready;
    logic [7:0] m_rx_byte;

    int errors = 0;
    int checks = 0;

    logic [7:0] bytes0 [8];
    logic [7:0] bytes1 [8];
    logic [7:0] rxlog0 [8];
    logic [7:0] rxlog1 [8];
    logic       men_at_rx [8];
    int idx0, idx1;
    int n_txn0, n_txn1, n_rxv0, n_rxv1, n_done0, n_done1;
    bit done_rx_ok, done_gnt_bad;

    spi_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .len0(len0), .len1(len1),
        .tx_data0(tx_data0), .tx_data1(tx_data1),
        .gnt0(gnt0), .gnt1(gnt1), .tx_next0(tx_next0), .tx_next1(tx_next1),
        .rx_data(rx_data), .rx_valid0(rx_valid0), .rx_valid1(rx_valid1),
        .done0(done0), .done1(done1), .m_en(m_en), .m_tx_byte(m_tx_byte),
        .m_tx_ready(m_tx_ready), .m_rx_ready(m_rx_ready), .m_rx_byte(m_rx_byte)
    );

    always #5 clk = ~clk;

    task automatic clear_counts;
        idx0 = 0; idx1 = 0;
        n_txn0 = 0; n_txn1 = 0; n_rxv0 = 0; n_rxv1 = 0; n_done0 = 0; n_done1 = 0;
        done_rx_ok = 1'b1; done_gnt_bad = 1'b0;
        tx_data0 = bytes0[0];
        tx_data1 = bytes1[0];
    endtask

    // One clock: wait for the falling edge, then record pulses and advance requester data.
    task automatic tick;
        @(negedge clk);
        if (tx_next0) begin n_txn0++; if (idx0 < 7) idx0++; tx_data0 = bytes0[idx0]; end
        if (tx_next1) begin n_txn1++; if (idx1 < 7) idx1++; tx_data1 = bytes1[idx1]; end
        if (rx_valid0) begin if (n_rxv0 < 8) rxlog0[n_rxv0] = rx_data; n_rxv0++; end
        if (rx_valid1) begin if (n_rxv1 < 8) rxlog1[n_rxv1] = rx_data; n_rxv1++; end
        if (done0) begin n_done0++; if (!rx_valid0) done_rx_ok = 1'b0; if (gnt0) done_gnt_bad = 1'b1; end
        if (done1) begin n_done1++; if (!rx_valid1) done_rx_ok = 1'b0; if (gnt1) done_gnt_bad = 1'b1; end
    endtask

    // Loopback master: launch the granted byte, receive it back one cycle later.
    task automatic xfer(input int nbytes);
        logic [7:0] b;
        for (int k = 0; k < nbytes; k++) begin
            m_tx_ready = 1'b1;
            b = m_tx_byte;
            tick();
            m_tx_ready = 1'b0;
            m_rx_ready = 1'b1;
            m_rx_byte  = b;
            if (k < 8) men_at_rx[k] = m_en;
            tick();
            m_rx_ready = 1'b0;
        end
    endtask

    task automatic wait_gnt(input int who);
        int n = 0;
        while (!(who == 1 ? gnt1 : gnt0) && n < 10) begin tick(); n++; end
        checks++;
        if (!(who == 1 ? gnt1 : gnt0)) begin
            errors++;
            $display("[TB] FAIL grant_timeout: requester %0d not granted after %0d cycles, required within 10", who, n);
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; len0 = 4'd0; len1 = 4'd0;
        m_tx_ready = 1'b0; m_rx_ready = 1'b0; m_rx_byte = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({gnt0, gnt1, m_en, tx_next0, tx_next1, rx_valid0, rx_valid1, done0, done1} !== 9'b0) begin
            errors++; $display("[TB] FAIL reset_outputs: got %b required 0", {gnt0, gnt1, m_en, done0, done1});
        end
        checks++;
        if (rx_data !== 8'h00 || m_tx_byte !== 8'h00) begin
            errors++; $display("[TB] FAIL reset_data: rx_data=%h m_tx_byte=%h required 00", rx_data, m_tx_byte);
        end
        tick(); tick();
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            errors++; $display("[TB] FAIL no_req_grant: gnt=%b%b required 00", gnt0, gnt1);
        end
    endtask

    task automatic test_single_byte;
        bytes0[0] = 8'hA5; len0 = 4'd1;
        clear_counts();
        req0 = 1'b1;
        tick();
        checks++;
        if ({gnt0, gnt1, m_en} !== 3'b101 || m_tx_byte !== 8'hA5) begin
            errors++; $display("[TB] FAIL single_grant: gnt0/gnt1/m_en=%b%b%b byte=%h required 101 A5", gnt0, gnt1, m_en, m_tx_byte);
        end
        xfer(1);
        req0 = 1'b0;
        checks++;
        if (n_rxv0 !== 1 || rxlog0[0] !== 8'hA5) begin
            errors++; $display("[TB] FAIL single_rx: count=%0d data=%h required 1 A5", n_rxv0, rxlog0[0]);
        end
        checks++;
        if (n_done0 !== 1 || !done_rx_ok || done_gnt_bad) begin
            errors++; $display("[TB] FAIL single_done: done=%0d with_rx=%0d gnt_at_done=%0d required 1 1 0", n_done0, done_rx_ok, done_gnt_bad);
        end
        checks++;
        if (n_txn0 !== 0 || n_txn1 !== 0 || n_rxv1 !== 0) begin
            errors++; $display("[TB] FAIL single_no_next: tx_next0=%0d tx_next1=%0d rx_valid1=%0d required 0 0 0", n_txn0, n_txn1, n_rxv1);
        end
        tick(); tick();
    endtask

    task automatic test_multi_byte;
        bytes1[0] = 8'h11; bytes1[1] = 8'h22; bytes1[2] = 8'h33; len1 = 4'd3;
        clear_counts();
        req1 = 1'b1;
        wait_gnt(1);
        xfer(3);
        req1 = 1'b0;
        checks++;
        if (n_txn1 !== 2 || n_txn0 !== 0) begin
            errors++; $display("[TB] FAIL multi_tx_next: tx_next1=%0d tx_next0=%0d required 2 0", n_txn1, n_txn0);
        end
        checks++;
        if (n_rxv1 !== 3 || rxlog1[0] !== 8'h11 || rxlog1[1] !== 8'h22 || rxlog1[2] !== 8'h33) begin
            errors++; $display("[TB] FAIL multi_rx: count=%0d data=%h %h %h required 3 11 22 33", n_rxv1, rxlog1[0], rxlog1[1], rxlog1[2]);
        end
        checks++;
        if (n_done1 !== 1 || !done_rx_ok || n_rxv0 !== 0) begin
            errors++; $display("[TB] FAIL multi_done: done1=%0d with_rx=%0d rx_valid0=%0d required 1 1 0", n_done1, done_rx_ok, n_rxv0);
        end
        checks++;
        if (men_at_rx[0] !== 1'b1 || men_at_rx[2] !== 1'b0) begin
            errors++; $display("[TB] FAIL multi_m_en: m_en at rx1=%b rx3=%b required 1 0", men_at_rx[0], men_at_rx[2]);
        end
        tick(); tick();
    endtask

    task automatic test_tie;
        int gap;
        do_reset();
        bytes0[0] = 8'h0A; bytes0[1] = 8'h0B; bytes1[0] = 8'h1A; bytes1[1] = 8'h1B;
        len0 = 4'd2; len1 = 4'd2;
        clear_counts();
        req0 = 1'b1; req1 = 1'b1;
        tick();
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            errors++; $display("[TB] FAIL tie_first: gnt0/gnt1=%b%b required 10", gnt0, gnt1);
        end
        xfer(2);
        req0 = 1'b0;
        checks++;
        if (n_done0 !== 1 || rxlog0[1] !== 8'h0B || m_en !== 1'b0) begin
            errors++; $display("[TB] FAIL tie_done0: done0=%0d last_rx=%h m_en=%b required 1 0B 0", n_done0, rxlog0[1], m_en);
        end
        gap = 0;
        while (!gnt1 && gap < 10) begin tick(); gap++; end
        checks++;
        if (gnt1 !== 1'b1 || gap !== 2) begin
            errors++; $display("[TB] FAIL tie_gap: gnt1=%b after %0d cycles required 1 after 2", gnt1, gap);
        end
        req0 = 1'b1;
        tick();
        checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            errors++; $display("[TB] FAIL tie_no_preempt: gnt0/gnt1=%b%b required 01", gnt0, gnt1);
        end
        xfer(2);
        checks++;
        if (n_done1 !== 1 || rxlog1[0] !== 8'h1A || rxlog1[1] !== 8'h1B) begin
            errors++; $display("[TB] FAIL tie_serve1: done1=%0d data=%h %h required 1 1A 1B", n_done1, rxlog1[0], rxlog1[1]);
        end
        idx0 = 0; idx1 = 0; tx_data0 = bytes0[0]; tx_data1 = bytes1[0];
        gap = 0;
        while (!(gnt0 || gnt1) && gap < 10) begin tick(); gap++; end
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            errors++; $display("[TB] FAIL tie_second: gnt0/gnt1=%b%b required 10", gnt0, gnt1);
        end
        xfer(2);
        req0 = 1'b0; req1 = 1'b0;
        checks++;
        if (n_done0 !== 2) begin
            errors++; $display("[TB] FAIL tie_second_done: done0=%0d required 2", n_done0);
        end
        tick(); tick();
    endtask

    task automatic test_len_zero;
        bytes0[0] = 8'h3C; len0 = 4'd0;
        clear_counts();
        req0 = 1'b1;
        wait_gnt(0);
        xfer(1);
        req0 = 1'b0;
        checks++;
        if (n_done0 !== 1 || n_rxv0 !== 1 || rxlog0[0] !== 8'h3C) begin
            errors++; $display("[TB] FAIL len0_done: done0=%0d rx=%0d data=%h required 1 1 3C", n_done0, n_rxv0, rxlog0[0]);
        end
        checks++;
        if (n_txn0 !== 0 || men_at_rx[0] !== 1'b0) begin
            errors++; $display("[TB] FAIL len0_single: tx_next0=%0d m_en_at_rx=%b required 0 0", n_txn0, men_at_rx[0]);
        end
        tick(); tick();
    endtask

    task automatic test_reset_mid;
        bytes0[0] = 8'h41; bytes0[1] = 8'h42; bytes0[2] = 8'h43; bytes0[3] = 8'h44; len0 = 4'd4;
        clear_counts();
        req0 = 1'b1;
        wait_gnt(0);
        xfer(1);
        m_tx_ready = 1'b1;
        tick();
        m_tx_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt0, gnt1, m_en, tx_next0, tx_next1, rx_valid0, rx_valid1, done0, done1} !== 9'b0
            || rx_data !== 8'h00 || m_tx_byte !== 8'h00) begin
            errors++; $display("[TB] FAIL reset_mid: ctrl=%b%b%b%b rx_data=%h required 0000 00", gnt0, gnt1, m_en, tx_next0, rx_data);
        end
        req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bytes1[0] = 8'h77; len1 = 4'd1;
        clear_counts();
        req1 = 1'b1;
        wait_gnt(1);
        xfer(1);
        req1 = 1'b0;
        checks++;
        if (n_done1 !== 1 || n_rxv1 !== 1 || rxlog1[0] !== 8'h77 || n_done0 !== 0) begin
            errors++; $display("[TB] FAIL reset_recover: done1=%0d rx1=%0d data=%h done0=%0d required 1 1 77 0", n_done1, n_rxv1, rxlog1[0], n_done0);
        end
    endtask

    task automatic test_stray;
        // First strobe lands in the GAP cycle right after done1, later ones in IDLE.
        clear_counts();
        m_rx_ready = 1'b1; m_rx_byte = 8'hC3;
        tick();
        m_tx_ready = 1'b1;
        tick();
        m_rx_ready = 1'b0; m_tx_ready = 1'b0;
        tick();
        checks++;
        if (n_rxv0 !== 0 || n_rxv1 !== 0 || n_txn0 !== 0 || n_txn1 !== 0) begin
            errors++; $display("[TB] FAIL stray_pulses: rx_valid=%0d/%0d tx_next=%0d/%0d required 0", n_rxv0, n_rxv1, n_txn0, n_txn1);
        end
        checks++;
        if (rx_data !== 8'h77 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            errors++; $display("[TB] FAIL stray_data: rx_data=%h gnt=%b%b required 77 00", rx_data, gnt0, gnt1);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            bytes0[i] = 8'h00; bytes1[i] = 8'h00; rxlog0[i] = 8'h00; rxlog1[i] = 8'h00; men_at_rx[i] = 1'b0;
        end
        tx_data0 = 8'h00; tx_data1 = 8'h00;
        clear_counts();
        test_reset();
        test_single_byte();
        test_multi_byte();
        test_tie();
        test_len_zero();
        test_reset_mid();
        test_stray();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
